// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset and system reset from an asynchronous PLL LOCK signal.
// Retries the PLL on lock timeout, qualifies lock before release, counts losses and retries.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 48,
    parameter int LOCK_TIMEOUT   = 48000,
    parameter int STABLE_CYCLES  = 4800,
    parameter int CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK,
    output logic       PLL_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] LOSS_CNT,
    output logic [7:0] RETRY_CNT
);

    // state     | meaning
    // ST_PLLRST | PLL held in reset for PLL_RST_CYCLES
    // ST_WAIT   | waiting for synchronised lock, times out into a retry
    // ST_STABLE | lock must stay high for STABLE_CYCLES before release
    // ST_RUN    | system released, READY high, watching for lock loss
    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [CNT_W-1:0]       cnt;
    logic                   lock_drop;
    logic                   timeout;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
        end
    end

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign lock_drop = (state == ST_RUN) && !lock_s;
    assign timeout   = (state == ST_WAIT) && !lock_s && (cnt == TIMEOUT_LAST);

    // Lock wins over timeout in WAIT, so a late lock is never thrown away.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_PLLRST: if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (lock_s)       state_nxt = ST_STABLE;
                else if (timeout) state_nxt = ST_PLLRST;
            end
            ST_STABLE: begin
                if (!lock_s)                  state_nxt = ST_WAIT;
                else if (cnt == STABLE_LAST)  state_nxt = ST_RUN;
            end
            ST_RUN:    if (!lock_s) state_nxt = ST_WAIT;
            default:   state_nxt = ST_PLLRST;
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_PLLRST;
            cnt       <= '0;
            PLL_RST   <= 1'b1;
            SYS_RST   <= 1'b1;
            READY     <= 1'b0;
            LOCK_LOST <= 1'b0;
            LOSS_CNT  <= 8'd0;
            RETRY_CNT <= 8'd0;
        end else begin
            state     <= state_nxt;
            if ((state_nxt != state) || (state == ST_RUN)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            PLL_RST   <= (state_nxt == ST_PLLRST);
            SYS_RST   <= (state_nxt != ST_RUN);
            READY     <= (state_nxt == ST_RUN);
            LOCK_LOST <= lock_drop;
            if (lock_drop && (LOSS_CNT != 8'hFF)) begin
                LOSS_CNT <= LOSS_CNT + 8'd1;
            end
            if (timeout && (RETRY_CNT != 8'hFF)) begin
                RETRY_CNT <= RETRY_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: every output change is matched
// against a queue of hand-computed (cycle, output snapshot) events.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_cnt;
    logic [7:0] retry_cnt;

    typedef struct {
        int          cyc;
        logic [19:0] snap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    pll_lock_sequencer #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .CNT_W         (16)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .LOCK     (lock),
        .PLL_RST  (pll_rst),
        .SYS_RST  (sys_rst),
        .READY    (ready),
        .LOCK_LOST(lock_lost),
        .LOSS_CNT (loss_cnt),
        .RETRY_CNT(retry_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] mk(input logic p, input logic s, input logic r,
                                       input logic l, input logic [7:0] lo,
                                       input logic [7:0] re);
        return {p, s, r, l, lo, re};
    endfunction

    function automatic logic [7:0] sat(input int k);
        return (k > 255) ? 8'd255 : 8'(k);
    endfunction

    task automatic push(input int c, input logic [19:0] s);
        exp_t e;
        e.cyc  = c;
        e.snap = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any change of the output snapshot is an event to be matched.
    initial begin
        logic [19:0] snap;
        logic [19:0] prev;
        bit          first;
        exp_t        e;
        prev  = '0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                snap = {pll_rst, sys_rst, ready, lock_lost, loss_cnt, retry_cnt};
                if (first || (snap != prev)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cycle %0d: got outputs %h, none expected", cyc, snap);
                    end else begin
                        e = exp_q.pop_front();
                        if (snap !== e.snap) begin
                            errors++;
                            $display("FAIL outputs cycle %0d: got %h want %h", cyc, snap, e.snap);
                        end
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL event_cycle: got %0d want %0d (outputs %h)", cyc, e.cyc, e.snap);
                        end
                    end
                    prev  = snap;
                    first = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [19:0] rst_v;
        logic [19:0] wait_v;
        logic [19:0] run_v;
        int          b;
        rst_v  = mk(1, 1, 0, 0, 8'd0, 8'd0);
        wait_v = mk(0, 1, 0, 0, 8'd0, 8'd0);
        run_v  = mk(0, 0, 1, 0, 8'd0, 8'd0);

        // Lock stable from time 0, one-cycle reset pulse.
        rst  = 1'b1;
        lock = 1'b1;
        @(posedge clk);
        #1;
        push(1, rst_v);
        push(5, wait_v);
        push(14, run_v);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Lock loss in RUN, then relock.
        wait_cyc(20);
        lock = 1'b0;
        push(23, mk(0, 1, 0, 1, 8'd1, 8'd0));
        push(24, mk(0, 1, 0, 0, 8'd1, 8'd0));
        wait_cyc(24);
        lock = 1'b1;
        push(35, mk(0, 0, 1, 0, 8'd1, 8'd0));

        // Second loss; lock dropped for 3 cycles in the middle of STABLE.
        wait_cyc(40);
        lock = 1'b0;
        push(43, mk(0, 1, 0, 1, 8'd2, 8'd0));
        push(44, mk(0, 1, 0, 0, 8'd2, 8'd0));
        wait_cyc(44);
        lock = 1'b1;
        wait_cyc(49);
        lock = 1'b0;
        wait_cyc(52);
        lock = 1'b1;
        push(63, mk(0, 0, 1, 0, 8'd2, 8'd0));

        // Losses 3..5.
        b = 70;
        for (int k = 3; k <= 5; k++) begin
            wait_cyc(b);
            lock = 1'b0;
            push(b + 3, mk(0, 1, 0, 1, 8'(k), 8'd0));
            push(b + 4, mk(0, 1, 0, 0, 8'(k), 8'd0));
            wait_cyc(b + 4);
            lock = 1'b1;
            push(b + 15, mk(0, 0, 1, 0, 8'(k), 8'd0));
            b += 20;
        end

        // Reset in RUN with LOSS_CNT=5, lock still present.
        wait_cyc(130);
        rst = 1'b1;
        push(131, rst_v);
        wait_cyc(131);
        rst = 1'b0;
        push(135, wait_v);
        push(144, run_v);

        // lock_s rises exactly on the last WAIT cycle before timeout.
        wait_cyc(150);
        lock = 1'b0;
        rst  = 1'b1;
        push(151, rst_v);
        wait_cyc(151);
        rst = 1'b0;
        push(155, wait_v);
        wait_cyc(172);
        lock = 1'b1;
        push(183, run_v);

        // No lock at all: retries every 24 cycles, RETRY_CNT saturates.
        wait_cyc(190);
        lock = 1'b0;
        rst  = 1'b1;
        push(191, rst_v);
        wait_cyc(191);
        rst = 1'b0;
        push(195, wait_v);
        for (int k = 1; k <= 300; k++) begin
            push(191 + 24 * k, mk(1, 1, 0, 0, 8'd0, sat(k)));
            push(195 + 24 * k, mk(0, 1, 0, 0, 8'd0, sat(k)));
        end

        while ((exp_q.size() != 0) && (cyc < 7500)) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events want 0 (next at cycle %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
